// File: rtl/switch_packet_tx_if.sv
// Job, data-nibble and result handshakes between the array
// controller and the switch packet transmitter.
interface switch_packet_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_tile;
  logic       cmd_op;
  logic [3:0] cmd_weight;
  logic [1:0] cmd_next;
  logic [3:0] cmd_count;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] din;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;

  modport master (
    output cmd_valid, cmd_tile, cmd_op,
    output cmd_weight, cmd_next, cmd_count,
    output din_valid, din, res_ready,
    input  cmd_ready, din_ready,
    input  res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_tile, cmd_op,
    input  cmd_weight, cmd_next, cmd_count,
    input  din_valid, din, res_ready,
    output cmd_ready, din_ready,
    output res_valid, res_data
  );
endinterface

// File: rtl/switch_packet_tx.sv
// Serialises weight/config/data packets onto the 8-bit
// switch bus of a compute tile and returns each tile result.
module switch_packet_tx #(
  parameter int NUM_TILES  = 4,
  parameter int RESULT_LAT = 2,
  parameter int MAX_BURST  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  switch_packet_tx_if.slave   s,
  output logic [7:0]          tx_data,
  output logic [1:0]          tile_sel,
  input  logic [7:0]          tile_res,
  output logic                busy
);

  localparam int RW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WEIGHT, S_CONFIG,
    S_DATA, S_WAIT, S_RESULT
  } state_t;

  state_t         state;
  logic [1:0]     j_tile;
  logic           j_op;
  logic [3:0]     j_w;
  logic [1:0]     j_next;
  logic           j_skip_c;
  logic [RW-1:0]  remain;
  logic [3:0]     wcnt;
  logic           res_valid;
  logic [7:0]     res_data;

  logic [NUM_TILES-1:0] c_valid;
  logic [3:0]           c_w    [NUM_TILES];
  logic                 c_op   [NUM_TILES];
  logic [1:0]           c_next [NUM_TILES];

  logic skip_w, skip_c;

  assign skip_w = c_valid[s.cmd_tile]
               && c_w[s.cmd_tile] == s.cmd_weight;
  assign skip_c = c_valid[s.cmd_tile]
               && c_op[s.cmd_tile] == s.cmd_op
               && c_next[s.cmd_tile] == s.cmd_next;

  assign s.cmd_ready = (state == S_IDLE);
  assign s.din_ready = (state == S_DATA);
  assign s.res_valid = res_valid;
  assign s.res_data  = res_data;
  assign busy        = (state != S_IDLE);

  // tx_data is only ever loaded with a packet, never cleared
  // outside reset: a stray 8'h00 would zero the tile weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tx_data   <= 8'h00;
      tile_sel  <= 2'd0;
      res_data  <= 8'h00;
      res_valid <= 1'b0;
      j_tile    <= 2'd0;
      j_op      <= 1'b0;
      j_w       <= 4'd0;
      j_next    <= 2'd0;
      j_skip_c  <= 1'b0;
      remain    <= '0;
      wcnt      <= 4'd0;
      c_valid   <= '0;
      for (int i = 0; i < NUM_TILES; i++) begin
        c_w[i]    <= 4'd0;
        c_op[i]   <= 1'b0;
        c_next[i] <= 2'd0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (s.cmd_valid) begin
            j_tile   <= s.cmd_tile;
            j_op     <= s.cmd_op;
            j_w      <= s.cmd_weight;
            j_next   <= s.cmd_next;
            j_skip_c <= skip_c;
            remain   <= RW'(s.cmd_count);
            if (!skip_w)
              state <= S_WEIGHT;
            else if (!skip_c)
              state <= S_CONFIG;
            else if (s.cmd_count != 4'd0)
              state <= S_DATA;
          end
        end
        S_WEIGHT: begin
          tx_data     <= {4'b0000, j_w};
          tile_sel    <= j_tile;
          c_w[j_tile] <= j_w;
          if (!j_skip_c)
            state <= S_CONFIG;
          else if (remain != '0)
            state <= S_DATA;
          else
            state <= S_IDLE;
        end
        S_CONFIG: begin
          tx_data          <= {2'b01, j_next, 3'b000, j_op};
          tile_sel         <= j_tile;
          c_valid[j_tile]  <= 1'b1;
          c_op[j_tile]     <= j_op;
          c_next[j_tile]   <= j_next;
          state <= (remain != '0) ? S_DATA : S_IDLE;
        end
        S_DATA: begin
          if (s.din_valid) begin
            tx_data  <= {4'b1000, s.din};
            tile_sel <= j_tile;
            remain   <= remain - 1'b1;
            wcnt     <= 4'(RESULT_LAT - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) begin
            res_data  <= tile_res;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_RESULT: begin
          if (s.res_ready) begin
            res_valid <= 1'b0;
            state <= (remain != '0) ? S_DATA : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_packet_tx.sv
// Directed bench for switch_packet_tx with a small
// behavioural tile array answering on tile_res.
module tb_switch_packet_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [1:0] tile_sel;
  logic [7:0] tile_res;
  logic       busy;

  switch_packet_tx_if bus ();

  switch_packet_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (bus.slave),
    .tx_data  (tx_data),
    .tile_sel (tile_sel),
    .tile_res (tile_res),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Tile model: decodes whatever sits on the bus each cycle,
  // including a reset 8'h00 (which zeroes the weight).
  logic [3:0] t_w  [4] = '{default: 4'd0};
  logic       t_op [4] = '{default: 1'b0};
  logic [7:0] t_r  [4] = '{default: 8'd0};

  always @(posedge clk) begin
    unique case (tx_data[7:6])
      2'b00: t_w[tile_sel] <= tx_data[3:0];
      2'b01: t_op[tile_sel] <= tx_data[0];
      2'b10: t_r[tile_sel] <= t_op[tile_sel]
        ? 8'({4'd0, t_w[tile_sel]} - {4'd0, tx_data[3:0]})
        : 8'({4'd0, t_w[tile_sel]} + {4'd0, tx_data[3:0]});
      default: ;
    endcase
  end

  assign tile_res = t_r[tile_sel];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] t,
                        input logic       o,
                        input logic [3:0] w,
                        input logic [1:0] n,
                        input logic [3:0] c);
    int k = 0;
    bus.cmd_tile   = t;
    bus.cmd_op     = o;
    bus.cmd_weight = w;
    bus.cmd_next   = n;
    bus.cmd_count  = c;
    bus.cmd_valid  = 1'b1;
    while (!bus.cmd_ready && k < 20) begin
      tick();
      k++;
    end
    check("cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [3:0] d);
    int k = 0;
    bus.din       = d;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && k < 20) begin
      tick();
      k++;
    end
    check("din_ready", bus.din_ready, 1);
    tick();
    bus.din_valid = 1'b0;
    check("tx_data_pkt", tx_data, {4'h8, d});
  endtask

  task automatic result(input logic [7:0] exp);
    check("res_valid_e0", bus.res_valid, 0);
    tick();
    check("res_valid_e1", bus.res_valid, 0);
    tick();
    check("res_valid_e2", bus.res_valid, 1);
    check("res_data", bus.res_data, exp);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_valid_clr", bus.res_valid, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_tile  = 2'd0;
    bus.cmd_op    = 1'b0;
    bus.cmd_weight = 4'd0;
    bus.cmd_next  = 2'd0;
    bus.cmd_count = 4'd0;
    bus.din_valid = 1'b0;
    bus.din       = 4'd0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    check("rst_tx", tx_data, 8'h00);
    check("rst_sel", tile_sel, 0);
    check("rst_res", bus.res_data, 8'h00);
    check("rst_rv", bus.res_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("idle_rdy", bus.cmd_ready, 1);

    // 1: full job on tile 1
    accept(2'd1, 1'b0, 4'd3, 2'd2, 4'd1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_w", tx_data, 8'h03);
    check("t1_sel", tile_sel, 2'd1);
    tick();
    check("t1_cfg", tx_data, 8'h60);
    feed(4'd5);
    result(8'h08);
    check("t1_idle", busy, 0);

    // 2: same settings, weight and config skipped
    accept(2'd1, 1'b0, 4'd3, 2'd2, 4'd1);
    check("t2_din_rdy", bus.din_ready, 1);
    feed(4'd6);
    result(8'h09);

    // 3: configure only, op change
    accept(2'd1, 1'b1, 4'd3, 2'd2, 4'd0);
    check("t3_busy", busy, 1);
    tick();
    check("t3_cfg", tx_data, 8'h61);
    check("t3_idle", busy, 0);
    check("t3_rv", bus.res_valid, 0);

    // 4: burst of 3 with a stalled consumer
    accept(2'd2, 1'b1, 4'd9, 2'd0, 4'd3);
    tick();
    check("t4_w", tx_data, 8'h09);
    check("t4_sel", tile_sel, 2'd2);
    tick();
    check("t4_cfg", tx_data, 8'h41);
    feed(4'd1);
    tick();
    tick();
    check("t4_rv", bus.res_valid, 1);
    bus.din       = 4'd2;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_rd", bus.res_data, 8'h08);
      check("t4_hold_rv", bus.res_valid, 1);
      check("t4_hold_tx", tx_data, 8'h81);
      check("t4_hold_dr", bus.din_ready, 0);
      check("t4_hold_cr", bus.cmd_ready, 0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t4_rv_clr", bus.res_valid, 0);
    feed(4'd2);
    result(8'h07);
    feed(4'd3);
    result(8'h06);
    check("t4_idle", busy, 0);

    // 5: gaps on din, bus must hold the last packet
    accept(2'd3, 1'b0, 4'd2, 2'd1, 4'd2);
    tick();
    check("t5_w", tx_data, 8'h02);
    tick();
    check("t5_cfg", tx_data, 8'h50);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_gap_a", tx_data, 8'h50);
    end
    feed(4'd4);
    result(8'h06);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_gap_b", tx_data, 8'h84);
      check("t5_busy", busy, 1);
    end
    feed(4'd7);
    result(8'h09);

    // 6: reset during WAIT, then the job must resend all
    accept(2'd0, 1'b0, 4'd1, 2'd3, 4'd1);
    tick();
    check("t6_w", tx_data, 8'h01);
    check("t6_sel", tile_sel, 2'd0);
    tick();
    check("t6_cfg", tx_data, 8'h70);
    feed(4'd2);
    tick();
    rst_n = 1'b0;
    #2;
    check("t6_rst_tx", tx_data, 8'h00);
    check("t6_rst_sel", tile_sel, 0);
    check("t6_rst_rd", bus.res_data, 8'h00);
    check("t6_rst_rv", bus.res_valid, 0);
    check("t6_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    accept(2'd0, 1'b0, 4'd1, 2'd3, 4'd1);
    tick();
    check("t6_w2", tx_data, 8'h01);
    tick();
    check("t6_cfg2", tx_data, 8'h70);
    feed(4'd2);
    result(8'h03);
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
